adc_scan_controller: RTL and testbench
======================================

Name: adc_scan_controller

Overview:
Multi-channel scan sequencer for the accumulating ADC datapath. It walks a latched channel-enable mask in ascending order. For each enabled channel it selects the analog input mux, pulses the converter start, waits for conversion done with a timeout, and stores the result in a per-channel register. A host-side read port returns the stored results with per-channel fresh flags. Scans run single-shot or continuously.

Parameters:
NUM_CH, 4, number of analog channels (2..16)
CH_W, 2, channel index width, equal to clog2(NUM_CH)
DATA_W, 8, conversion result width
TIMEOUT, 300, maximum WAIT cycles per conversion before abort (must exceed 257, the converter's worst case)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
en_mask  input  NUM_CH  channel enables, latched at scan start
scan_go  input  1  single-cycle pulse that requests one scan
continuous  input  1  level; when high, a new scan auto-starts from IDLE
adc_start  output  1  one-cycle start pulse to the converter
adc_ch_sel  output  CH_W  analog mux select, held stable from START through WAIT
adc_done  input  1  conversion-complete indication from the converter
adc_data  input  DATA_W  converter result, valid while adc_done=1
rd_ch  input  CH_W  host read channel select
rd_ack  input  1  host acknowledges a read; clears fresh[rd_ch]
rd_data  output  DATA_W  result[rd_ch], combinational
rd_valid  output  1  fresh[rd_ch], combinational
busy  output  1  high in every state except IDLE
scan_done  output  1  one-cycle pulse when a scan completes
timeout_err  output  1  sticky flag; set when any conversion times out
err_clr  input  1  clears timeout_err

Behaviour:
- Reset values:
  - state=IDLE; adc_start=0; adc_ch_sel=0; busy=0; scan_done=0; timeout_err=0.
  - All result registers are 0 and all fresh flags are 0; the WAIT timer and latched mask are 0.
- Reset asserted mid-scan aborts immediately. No further adc_start is issued and no result is written.
- States: IDLE, START, WAIT, NEXT.
- IDLE:
  - A scan starts when (scan_go or continuous) and en_mask!=0.
  - On start: latch en_mask, set cur_ch to the lowest set bit, and go to START.
  - If en_mask==0 the request is dropped: stay in IDLE, no scan_done pulse.
- START:
  - adc_start=1 for exactly this cycle; adc_ch_sel=cur_ch; the timer clears to 0.
  - Next state is WAIT.
  - Latency: scan_go sampled in cycle N gives adc_start=1 in cycle N+1.
- WAIT:
  - The timer increments each cycle.
  - If adc_done=1: write adc_data into result[cur_ch], set fresh[cur_ch], and go to NEXT.
  - Otherwise, when the timer reaches TIMEOUT-1: set timeout_err, leave result and fresh unchanged, and go to NEXT.
  - If adc_done=1 and the timeout fire in the same cycle, adc_done wins and no error is set.
- NEXT:
  - If the latched mask has a set bit above cur_ch, set cur_ch to the lowest such bit and go to START.
  - Otherwise pulse scan_done=1 this cycle and go to IDLE.
- Continuous mode: back-to-back scans start with exactly one IDLE cycle between scan_done and the next START.
- adc_done is ignored in IDLE, START and NEXT.
- scan_go while busy is ignored and is not queued.
- Changes to en_mask during a scan do not affect that scan.
- Read port:
  - rd_data and rd_valid are combinational from rd_ch.
  - rd_ack clears fresh[rd_ch] on the next edge.
  - If rd_ack and a store target the same channel in the same cycle, the store wins: fresh stays 1 and result updates.
  - A new conversion overwrites result even if fresh=1 (no overrun blocking).
- err_clr clears timeout_err; if err_clr and a new timeout coincide, the set wins.
- Width rules:
  - The timer is wide enough to hold TIMEOUT-1 and never wraps.
  - adc_ch_sel never takes a value >= NUM_CH.

Test Plan:
- Single scan: en_mask=4'b1010, scan_go pulse; converter model returns 8'h5A on ch1 and 8'h3C on ch3 after 256 cycles. Required: adc_start on ch1 then ch3, result[1]=5A, result[3]=3C, fresh=1010, one scan_done pulse, busy low afterwards.
- Empty mask: en_mask=0, scan_go pulse. Required: stays in IDLE, adc_start never asserts, busy=0, no scan_done.
- Timeout: en_mask=4'b0001 and the model never asserts adc_done. Required: adc_start, then exactly TIMEOUT WAIT cycles, timeout_err=1, result[0] unchanged, scan_done pulse. Then err_clr pulse clears timeout_err to 0.
- Continuous mode: continuous=1, en_mask=4'b0011, with en_mask changed to 4'b0100 mid-scan. Required: first scan covers ch0 and ch1; one IDLE cycle; second scan covers ch2 only.
- Read/store collision: rd_ch=2 with rd_ack=1 in the same cycle adc_done stores 8'hFF for ch2. Required: fresh[2] stays 1 and rd_data=FF. Then rd_ack alone clears rd_valid to 0.
- Reset mid-WAIT: assert rst during the ch1 conversion. Required: all outputs and results return to reset values next cycle, and a late adc_done produces no write.

Source files
------------

// File: rtl/adc_scan_controller.sv
// Purpose: multi-channel ADC scan sequencer. It walks the latched enable mask in ascending order and stores one result per channel.
// Latency: a request sampled in cycle N gives adc_start in N+1. Each channel takes START + WAIT (done or timeout) + NEXT.
// Backpressure: none. scan_go while busy is dropped. New results overwrite unread ones. Reads are combinational.
// Ports: clk/rst (sync, active-high); en_mask/scan_go/continuous start scans;
//        adc_start/adc_ch_sel/adc_done/adc_data talk to the converter;
//        rd_ch/rd_ack/rd_data/rd_valid form the host read port;
//        busy/scan_done/timeout_err/err_clr report status.
module adc_scan_controller #(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 300
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en_mask,
    input  logic              scan_go,
    input  logic              continuous,
    output logic              adc_start,
    output logic [CH_W-1:0]   adc_ch_sel,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              scan_done,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam int TMR_W = $clog2(TIMEOUT);
    // Storage is sized to the full index space so rd_ch can never address
    // past the array. Slots at or above NUM_CH are never written and read as 0.
    localparam int NSLOT = 1 << CH_W;

    typedef enum logic [1:0] {IDLE, START, WAIT, NEXT} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] result_q [NSLOT];
    logic [DATA_W-1:0] result_d [NSLOT];
    logic [NSLOT-1:0]  fresh_q, fresh_d;
    logic              err_q, err_d;

    logic [CH_W-1:0]   first_ch;
    logic [CH_W-1:0]   next_ch;
    logic              next_found;

    // Priority encoders. Scanning downward makes the last hit the lowest bit.
    always_comb begin
        first_ch   = '0;
        next_ch    = '0;
        next_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (en_mask[i]) begin
                first_ch = CH_W'(i);
            end
            if (mask_q[i] && (i > int'(cur_ch_q))) begin
                next_ch    = CH_W'(i);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_ch_d  = cur_ch_q;
        mask_d    = mask_q;
        timer_d   = timer_q;
        result_d  = result_q;
        fresh_d   = fresh_q;
        err_d     = err_q;
        adc_start = 1'b0;
        scan_done = 1'b0;

        // Clears are applied first so a same-cycle store or timeout overrides them.
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (rd_ack) begin
            fresh_d[rd_ch] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if ((scan_go || continuous) && (en_mask != '0)) begin
                    mask_d   = en_mask;
                    cur_ch_d = first_ch;
                    state_d  = START;
                end
            end
            START: begin
                adc_start = 1'b1;
                timer_d   = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                // adc_done takes priority over a timeout in the same cycle.
                if (adc_done) begin
                    result_d[cur_ch_q] = adc_data;
                    fresh_d[cur_ch_q]  = 1'b1;
                    state_d            = NEXT;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = NEXT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            NEXT: begin
                if (next_found) begin
                    cur_ch_d = next_ch;
                    state_d  = START;
                end else begin
                    scan_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_ch_q <= '0;
            mask_q   <= '0;
            timer_q  <= '0;
            fresh_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                result_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cur_ch_q <= cur_ch_d;
            mask_q   <= mask_d;
            timer_q  <= timer_d;
            fresh_q  <= fresh_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign adc_ch_sel  = cur_ch_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = err_q;
    assign rd_data     = result_q[rd_ch];
    assign rd_valid    = fresh_q[rd_ch];

endmodule

// File: tb/tb_adc_scan_controller.sv
module tb_adc_scan_controller;
    localparam int NUM_CH  = 4;
    localparam int CH_W    = 2;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic [NUM_CH-1:0] en_mask = '0;
    logic              scan_go = 1'b0;
    logic              continuous = 1'b0;
    logic              adc_start;
    logic [CH_W-1:0]   adc_ch_sel;
    logic              adc_done = 1'b0;
    logic [DATA_W-1:0] adc_data = '0;
    logic [CH_W-1:0]   rd_ch = '0;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              scan_done;
    logic              timeout_err;
    logic              err_clr = 1'b0;

    logic host_ack  = 1'b0;
    logic model_ack = 1'b0;
    assign rd_ack = host_ack | model_ack;

    adc_scan_controller #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .en_mask(en_mask), .scan_go(scan_go),
        .continuous(continuous), .adc_start(adc_start), .adc_ch_sel(adc_ch_sel),
        .adc_done(adc_done), .adc_data(adc_data), .rd_ch(rd_ch), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .scan_done(scan_done),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: the channels expected on each adc_start, in order.
    int exp_ch_q[$];
    int model_delay = 1;                  // 0 = converter never answers
    logic [DATA_W-1:0] model_data [NUM_CH];
    bit ack_on_done = 1'b0;
    int cnt = 0;
    int last_start_cyc = 0;

    logic [DATA_W-1:0] exp_res [NUM_CH];
    bit                exp_fresh [NUM_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Converter model plus the scoreboard monitor on adc_start.
    always begin
        int e;
        @(posedge clk);
        #1;
        adc_done  = 1'b0;
        model_ack = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                adc_done  = 1'b1;
                adc_data  = model_data[adc_ch_sel];
                model_ack = ack_on_done;
            end
        end
        if (adc_start) begin
            checks++;
            if (exp_ch_q.size() == 0) begin
                errors++;
                $display("FAIL adc_start: got start on ch %0d expected none", adc_ch_sel);
            end else begin
                e = exp_ch_q.pop_front();
                if (int'(adc_ch_sel) != e) begin
                    errors++;
                    $display("FAIL adc_ch_sel: got %0d expected %0d", adc_ch_sel, e);
                end
            end
            cnt = model_delay;
            last_start_cyc = cyc;
        end
    end

    task automatic wait_scan(input int budget, output int pulses, output int dur);
        pulses = 0;
        dur = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (scan_done) begin
                pulses++;
                dur = cyc - last_start_cyc;
            end
            if (!busy && pulses > 0) break;
        end
    endtask

    task automatic check_reads(input string tag);
        for (int c = 0; c < NUM_CH; c++) begin
            rd_ch = CH_W'(c);
            #1;
            check({tag, " rd_valid"}, rd_valid, exp_fresh[c]);
            check({tag, " rd_data"}, rd_data, exp_res[c]);
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < NUM_CH; c++) begin
            exp_res[c] = '0;
            exp_fresh[c] = 1'b0;
        end
    endtask

    typedef struct {
        logic [NUM_CH-1:0] mask;
        int                delay;
        logic [31:0]       data;    // byte c = result for channel c
        logic              exp_err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int pulses, dur, eff, n;
        bit seen;

        vecs[0] = '{4'b1010, 256, 32'h3C00_5A00, 1'b0};   // basic two-channel scan
        vecs[1] = '{4'b0000, 5,   32'h0000_0000, 1'b0};   // empty mask is dropped
        vecs[2] = '{4'b0001, 0,   32'h0000_00EE, 1'b1};   // converter silent -> timeout
        vecs[3] = '{4'b1111, 3,   32'h4433_2211, 1'b0};   // all channels
        vecs[4] = '{4'b1000, 300, 32'h7700_0000, 1'b0};   // done on the timeout cycle
        vecs[5] = '{4'b0101, 1,   32'h0099_0088, 1'b0};   // fastest converter

        clear_model();
        tick();
        tick();
        rst = 1'b0;
        check("reset busy", busy, 0);
        check("reset adc_start", adc_start, 0);
        check("reset adc_ch_sel", adc_ch_sel, 0);
        check("reset scan_done", scan_done, 0);
        check("reset timeout_err", timeout_err, 0);
        check_reads("reset");

        for (int v = 0; v < 6; v++) begin
            model_delay = vecs[v].delay;
            for (int c = 0; c < NUM_CH; c++) begin
                model_data[c] = vecs[v].data[8*c +: 8];
                if (vecs[v].mask[c]) begin
                    exp_ch_q.push_back(c);
                    if (vecs[v].delay != 0) begin
                        exp_res[c]   = vecs[v].data[8*c +: 8];
                        exp_fresh[c] = 1'b1;
                    end
                end
            end
            eff = (vecs[v].delay == 0) ? TIMEOUT : vecs[v].delay;
            en_mask = vecs[v].mask;
            scan_go = 1'b1;
            tick();
            scan_go = 1'b0;
            if (vecs[v].mask == '0) begin
                check("empty adc_start", adc_start, 0);
                n = 0;
                for (int i = 0; i < 10; i++) begin
                    if (scan_done) n++;
                    if (busy) n++;
                    tick();
                end
                check("empty busy/scan_done cycles", n, 0);
            end else begin
                check("start latency adc_start", adc_start, 1);
                check("start busy", busy, 1);
                wait_scan(2000, pulses, dur);
                check("scan_done pulses", pulses, 1);
                check("last channel duration", dur, eff + 1);
                check("busy after scan", busy, 0);
            end
            check("starts outstanding", exp_ch_q.size(), 0);
            check("timeout_err", timeout_err, vecs[v].exp_err);
            check_reads("vector");
            if (vecs[v].exp_err) begin
                err_clr = 1'b1;
                tick();
                err_clr = 1'b0;
                check("err_clr", timeout_err, 0);
            end
        end

        // Continuous mode, with the mask changed mid-scan.
        model_delay = 2;
        model_data[0] = 8'hA0;
        model_data[1] = 8'hA1;
        model_data[2] = 8'hA2;
        exp_ch_q.push_back(0);
        exp_ch_q.push_back(1);
        exp_ch_q.push_back(2);
        en_mask = 4'b0011;
        continuous = 1'b1;
        tick();
        en_mask = 4'b0100;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (scan_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("cont first scan_done", seen, 1);
        tick();
        check("cont idle gap busy", busy, 0);
        check("cont idle gap adc_start", adc_start, 0);
        tick();
        check("cont restart adc_start", adc_start, 1);
        check("cont restart ch", adc_ch_sel, 2);
        continuous = 1'b0;
        wait_scan(200, pulses, dur);
        check("cont second scan_done", pulses, 1);
        check("cont starts outstanding", exp_ch_q.size(), 0);
        for (int c = 0; c < 3; c++) begin
            exp_res[c]   = model_data[c];
            exp_fresh[c] = 1'b1;
        end
        check_reads("cont");
        en_mask = '0;

        // rd_ack on ch2 in the store cycle; also scan_go while busy.
        rd_ch = 2;
        ack_on_done = 1'b1;
        model_delay = 4;
        model_data[2] = 8'hFF;
        exp_ch_q.push_back(2);
        en_mask = 4'b0100;
        scan_go = 1'b1;
        tick();
        tick();
        tick();    // scan_go still high while busy: must be ignored
        scan_go = 1'b0;
        wait_scan(200, pulses, dur);
        ack_on_done = 1'b0;
        rd_ch = 2;
        #1;
        check("collision rd_valid", rd_valid, 1);
        check("collision rd_data", rd_data, 8'hFF);
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
        check("ack clears rd_valid", rd_valid, 0);
        for (int i = 0; i < 5; i++) tick();
        check("no queued scan busy", busy, 0);
        check("no queued scan starts", exp_ch_q.size(), 0);
        en_mask = '0;

        // Reset in the middle of WAIT; the late adc_done must not be stored.
        model_delay = 50;
        model_data[1] = 8'h6B;
        exp_ch_q.push_back(1);
        en_mask = 4'b0010;
        scan_go = 1'b1;
        tick();
        scan_go = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("pre-reset busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        check("mid reset busy", busy, 0);
        check("mid reset adc_start", adc_start, 0);
        check("mid reset adc_ch_sel", adc_ch_sel, 0);
        check("mid reset scan_done", scan_done, 0);
        check("mid reset timeout_err", timeout_err, 0);
        check_reads("mid reset");
        for (int i = 0; i < 60; i++) tick();
        check("late done busy", busy, 0);
        check_reads("late done");
        check("late done starts outstanding", exp_ch_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
